// File: rtl/cmp_pkg.sv
// Shared types for the window monitor: FSM state encoding and per-sample class.
package cmp_pkg;

  typedef enum logic [2:0] {
    NORMAL  = 3'd0,
    PEND_HI = 3'd1,
    PEND_LO = 3'd2,
    ALM_HI  = 3'd3,
    ALM_LO  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CLS_IN    = 2'd0,
    CLS_ABOVE = 2'd1,
    CLS_BELOW = 2'd2
  } class_e;

  // Window edges are inside: only strict excursions classify as ABOVE/BELOW.
  function automatic class_e classify(input logic gt_hi, input logic lt_lo);
    if (gt_hi)      return CLS_ABOVE;
    else if (lt_lo) return CLS_BELOW;
    else            return CLS_IN;
  endfunction

endpackage

// File: rtl/n_bit_comparator.sv
// Unsigned magnitude comparator producing a>b and a<b flags.
module n_bit_comparator #(
  parameter int n = 16
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         greater,
  output logic         lesser
);

  assign greater = (a > b);
  assign lesser  = (a < b);

endmodule

// File: rtl/cmp_window_monitor.sv
// Window classifier with debounced, latched high/low alarms, entry pulse and
// saturating entry counter.
import cmp_pkg::*;

module cmp_window_monitor #(
  parameter int N        = 16,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  input  logic [N-1:0]     thr_hi,
  input  logic [N-1:0]     thr_lo,
  input  logic             clear,
  output logic             alarm_hi,
  output logic             alarm_lo,
  output logic             alarm_evt,
  output logic [CNT_W-1:0] evt_count,
  output logic             cfg_err
);

  localparam int                RUN_W   = $clog2(DEBOUNCE + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(DEBOUNCE);

  logic above, below, cfg_bad;
  logic unused_hi_lt, unused_lo_gt, unused_cfg_lt;

  n_bit_comparator #(.n(N)) u_cmp_hi (
    .a(in_data), .b(thr_hi), .greater(above), .lesser(unused_hi_lt)
  );
  n_bit_comparator #(.n(N)) u_cmp_lo (
    .a(in_data), .b(thr_lo), .greater(unused_lo_gt), .lesser(below)
  );
  n_bit_comparator #(.n(N)) u_cmp_cfg (
    .a(thr_lo), .b(thr_hi), .greater(cfg_bad), .lesser(unused_cfg_lt)
  );

  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alarm_hi_q, alarm_hi_d;
  logic             alarm_lo_q, alarm_lo_d;
  logic             evt_q, evt_d;
  logic             cfg_err_q, cfg_err_d;
  logic             accept, enter_hi, enter_lo;
  class_e           cls;

  assign cls     = classify(above, below);
  assign run_inc = run_q + 1'b1;
  // Stay frozen while the thresholds are bad and for the cycle they recover.
  assign accept  = in_valid && !cfg_bad && !cfg_err_q;

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    cnt_d     = cnt_q;
    evt_d     = 1'b0;
    cfg_err_d = cfg_bad;
    enter_hi  = 1'b0;
    enter_lo  = 1'b0;

    if (clear) begin
      state_d = NORMAL;
      run_d   = '0;
      cnt_d   = '0;
    end else if (accept) begin
      case (state_q)
        NORMAL: begin
          if (cls == CLS_ABOVE) begin
            if (DEBOUNCE == 1) enter_hi = 1'b1;
            else begin state_d = PEND_HI; run_d = RUN_W'(1); end
          end else if (cls == CLS_BELOW) begin
            if (DEBOUNCE == 1) enter_lo = 1'b1;
            else begin state_d = PEND_LO; run_d = RUN_W'(1); end
          end
        end
        PEND_HI: begin
          if (cls == CLS_ABOVE) begin
            if (run_inc == RUN_MAX) enter_hi = 1'b1;
            else                    run_d = run_inc;
          end else if (cls == CLS_BELOW) begin
            state_d = PEND_LO; run_d = RUN_W'(1);
          end else begin
            state_d = NORMAL;  run_d = '0;
          end
        end
        PEND_LO: begin
          if (cls == CLS_BELOW) begin
            if (run_inc == RUN_MAX) enter_lo = 1'b1;
            else                    run_d = run_inc;
          end else if (cls == CLS_ABOVE) begin
            state_d = PEND_HI; run_d = RUN_W'(1);
          end else begin
            state_d = NORMAL;  run_d = '0;
          end
        end
        ALM_HI, ALM_LO: begin
          // Leaving an alarm needs an unbroken run of in-window samples.
          if (cls == CLS_IN) begin
            if (run_inc == RUN_MAX) begin state_d = NORMAL; run_d = '0; end
            else                    run_d = run_inc;
          end else begin
            run_d = '0;
          end
        end
        default: begin
          state_d = NORMAL;
          run_d   = '0;
        end
      endcase

      if (enter_hi || enter_lo) begin
        state_d = enter_hi ? ALM_HI : ALM_LO;
        run_d   = '0;
        evt_d   = 1'b1;
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      end
    end

    alarm_hi_d = (state_d == ALM_HI);
    alarm_lo_d = (state_d == ALM_LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= NORMAL;
      run_q      <= '0;
      cnt_q      <= '0;
      evt_q      <= 1'b0;
      alarm_hi_q <= 1'b0;
      alarm_lo_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      cnt_q      <= cnt_d;
      evt_q      <= evt_d;
      alarm_hi_q <= alarm_hi_d;
      alarm_lo_q <= alarm_lo_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign alarm_hi  = alarm_hi_q;
  assign alarm_lo  = alarm_lo_q;
  assign alarm_evt = evt_q;
  assign evt_count = cnt_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_cmp_window_monitor.sv
// Scoreboard bench for cmp_window_monitor: a behavioural model predicts every
// cycle's outputs, which are queued at drive time and compared after the edge.
module tb_cmp_window_monitor;

  localparam int N   = 16;
  localparam int DEB = 4;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [N-1:0]  in_data;
  logic [N-1:0]  thr_hi;
  logic [N-1:0]  thr_lo;
  logic          clear;
  logic          alarm_hi, alarm_lo, alarm_evt, cfg_err;
  logic [CW-1:0] evt_count;

  cmp_window_monitor #(.N(N), .DEBOUNCE(DEB), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .clear(clear),
    .alarm_hi(alarm_hi), .alarm_lo(alarm_lo), .alarm_evt(alarm_evt),
    .evt_count(evt_count), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [11:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_txn    = 0;

  // Model state: which alarm is latched (0 none, 1 hi, 2 lo), pending direction, run length.
  int m_alarm, m_pend, m_run, m_cnt;
  bit m_evt, m_cfg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] obs();
    return {alarm_hi, alarm_lo, alarm_evt, evt_count, cfg_err};
  endfunction

  function automatic logic [11:0] model_outs();
    logic [7:0] c;
    c = m_cnt[7:0];
    return {m_alarm == 1, m_alarm == 2, m_evt, c, m_cfg};
  endfunction

  task automatic model_reset();
    m_alarm = 0; m_pend = 0; m_run = 0; m_cnt = 0; m_evt = 0; m_cfg = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit c);
    int cls;
    bit bad;
    bad   = (int'(thr_lo) > int'(thr_hi));
    cls   = (d > int'(thr_hi)) ? 1 : ((d < int'(thr_lo)) ? 2 : 0);
    m_evt = 0;
    if (c) begin
      m_alarm = 0; m_pend = 0; m_run = 0; m_cnt = 0;
    end else if (v && !bad && !m_cfg) begin
      if (m_alarm == 0) begin
        if (cls == 0) begin
          m_pend = 0; m_run = 0;
        end else if (cls == m_pend) begin
          m_run++;
        end else begin
          m_pend = cls; m_run = 1;
        end
        if (m_pend != 0 && m_run >= DEB) begin
          m_alarm = m_pend; m_pend = 0; m_run = 0; m_evt = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end else begin
        if (cls == 0) m_run++;
        else          m_run = 0;
        if (m_run >= DEB) begin
          m_alarm = 0; m_run = 0;
        end
      end
    end
    m_cfg = bad;
  endtask

  task automatic step(input string tag, input bit v, input int d, input bit c);
    exp_t e;
    in_valid = v;
    in_data  = N'(d);
    clear    = c;
    model_step(v, d, c);
    e.tag = tag;
    e.exp = model_outs();
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check(e.tag, 32'(obs()), 32'(e.exp));
    n_txn++;
    $display("txn %0d %s v=%0d d=%0d clr=%0d -> hi=%0d lo=%0d evt=%0d cnt=%0d cfg=%0d",
             n_txn, e.tag, v, d, c, alarm_hi, alarm_lo, alarm_evt, evt_count, cfg_err);
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic run(input string tag, input int d, input int count);
    for (int i = 0; i < count; i++) step(tag, 1'b1, d, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq3 [7] = '{50, 100, 150, 20, 50, 100, 20};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0;
    thr_hi = 16'd100; thr_lo = 16'd20;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset", 32'(obs()), 32'd0);
    rst_n = 1'b1;

    // 1: four back-to-back ABOVE samples enter the high alarm
    run("t1_above", 101, 3);
    check("t1_no_alarm_yet", 32'(alarm_hi), 32'd0);
    step("t1_enter", 1'b1, 101, 1'b0);
    check("t1_alarm_hi", 32'(alarm_hi), 32'd1);
    check("t1_evt", 32'(alarm_evt), 32'd1);
    check("t1_count", 32'(evt_count), 32'd1);
    step("t1_evt_gone", 1'b1, 50, 1'b0);
    check("t1_evt_one_cycle", 32'(alarm_evt), 32'd0);
    run("t1_exit", 50, 3);
    check("t1_exited", 32'(alarm_hi), 32'd0);

    // 2: an IN sample breaks the run; gaps neither advance nor break it
    run("t2_run", 101, 3);
    step("t2_break", 1'b1, 50, 1'b0);
    step("t2_restart", 1'b1, 101, 1'b0);
    check("t2_no_alarm", 32'(alarm_hi), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step("t2_gap", 1'b0, 101, 1'b0);
      step("t2_gap", 1'b0, 7, 1'b0);
      step("t2_gapped", 1'b1, 101, 1'b0);
    end
    check("t2_alarm_hi", 32'(alarm_hi), 32'd1);

    // 3: leaving ALM_HI needs four consecutive IN samples; window edges are IN
    for (int i = 0; i < 7; i++) step("t3_exit_seq", 1'b1, seq3[i], 1'b0);
    check("t3_dropped", 32'(alarm_hi), 32'd0);
    run("t3_reenter", 101, 4);
    run("t3_edges", 100, 2);
    run("t3_edges", 20, 1);
    check("t3_hold", 32'(alarm_hi), 32'd1);
    run("t3_edges", 20, 1);
    check("t3_edge_exit", 32'(alarm_hi), 32'd0);

    // 4: low alarm, then clear wins over a coincident sample
    run("t4_below", 5, 4);
    check("t4_alarm_lo", 32'(alarm_lo), 32'd1);
    step("t4_clear", 1'b1, 5, 1'b1);
    check("t4_cleared", 32'(obs()), 32'd0);
    run("t4_after", 5, 3);
    check("t4_sample_dropped", 32'(alarm_lo), 32'd0);
    run("t4_after", 5, 1);
    run("t4_exit", 60, 4);

    // 5: inverted thresholds freeze processing until one cycle after recovery
    thr_lo = 16'd200;
    run("t5_cfg_bad", 300, 8);
    check("t5_cfg_err", 32'(cfg_err), 32'd1);
    check("t5_no_alarm", 32'(alarm_hi), 32'd0);
    thr_lo = 16'd20;
    step("t5_recover", 1'b1, 300, 1'b0);
    check("t5_cfg_clear", 32'(cfg_err), 32'd0);
    run("t5_resume", 300, 4);
    check("t5_alarm_hi", 32'(alarm_hi), 32'd1);
    run("t5_exit", 50, 4);

    // 6: counter saturation, then asynchronous reset in the middle of a run
    step("t6_clear", 1'b0, 0, 1'b1);
    for (int k = 0; k < 300; k++) begin
      run("t6_enter", 101, 4);
      run("t6_leave", 50, 4);
    end
    check("t6_saturated", 32'(evt_count), 32'd255);
    run("t6_pend", 101, 2);
    rst_n = 1'b0;
    #2;
    check("t6_async_reset", 32'(obs()), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run("t6_restart", 101, 3);
    check("t6_no_carry", 32'(alarm_hi), 32'd0);
    run("t6_restart", 101, 1);
    check("t6_alarm", 32'(alarm_hi), 32'd1);
    check("t6_count_one", 32'(evt_count), 32'd1);

    if (sb_q.size() != 0) check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
